// File: rtl/io_bridge.sv
// io_bridge: CPU data bus to memory-mapped peripheral bridge.
//
// The address space is split into uniform windows of 2^SLOT_LSB bytes. The
// slot index is address[AW-1:SLOT_LSB]. Slots below NSLAVE are peripherals,
// the top slot holds the internal registers, and the remaining slots are
// unmapped. Each request issues one single-cycle strobe to the selected
// slot. The request then completes either after a fixed number of wait
// states or on a per-slot acknowledge, which is bounded by a timeout.
//
// Optional feature macro: IO_BRIDGE_IRQ_EN. When it is defined, the bridge
// has the IRQ_MASK register and drives a registered interrupt output. When
// it is undefined, interrupt is tied to 0 and IRQ_MASK reads as 0.
//
// Internal registers (top slot, selected by offset[3:2]):
//   0 IRQ_RAW  (RO)   1 IRQ_MASK (RW)   2 ERR (W1C)   3 ERR_ADDR (RO)
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   read, write           CPU request, held until wait_out is low
//   address, data_in, be  CPU byte address, write data, byte enables
//   data_out              registered read data
//   wait_out              stall to CPU, low only in the DONE cycle
//   s_read, s_write       one-hot single-cycle peripheral strobes
//   s_address/s_data/s_be registered in-window offset, write data, enables
//   s_readdata            flattened slave read data, slot i at [32i+31:32i]
//   s_ack                 completion acknowledge for ACK_MASK slots
//   irq_in, interrupt     level interrupt requests, aggregated interrupt
//
// state  | meaning
// IDLE   | waiting for read|write; a request is latched on acceptance
// ACCESS | strobe issued in the first cycle; waits for count or acknowledge
// DONE   | result visible, wait_out low; returns to IDLE unconditionally
module io_bridge #(
  parameter int               NSLAVE      = 4,
  parameter int               AW          = 11,
  parameter int               SLOT_LSB    = 8,
  parameter int               WAIT_STATES = 1,
  parameter logic [NSLAVE-1:0] ACK_MASK   = '0,
  parameter int               TIMEOUT     = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  read,
  input  logic                  write,
  input  logic [AW-1:0]         address,
  input  logic [31:0]           data_in,
  input  logic [3:0]            be,
  output logic [31:0]           data_out,
  output logic                  wait_out,
  output logic [NSLAVE-1:0]     s_read,
  output logic [NSLAVE-1:0]     s_write,
  output logic [SLOT_LSB-1:0]   s_address,
  output logic [31:0]           s_data,
  output logic [3:0]            s_be,
  input  logic [32*NSLAVE-1:0]  s_readdata,
  input  logic [NSLAVE-1:0]     s_ack,
  input  logic [NSLAVE-1:0]     irq_in,
  output logic                  interrupt
);

  localparam int SW   = AW - SLOT_LSB;
  localparam int CMAX = (TIMEOUT > WAIT_STATES) ? TIMEOUT : WAIT_STATES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [SW-1:0] TOP_SLOT = {SW{1'b1}};
  localparam logic [CW-1:0] WS_LOAD  = CW'(WAIT_STATES - 1);
  localparam logic [CW-1:0] TO_LOAD  = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, next_state;

  logic [SW-1:0]     slot_q;
  logic              is_wr_q, is_int_q, is_unm_q, is_ack_q;
  logic [CW-1:0]     cnt;
  logic [1:0]        err_q;
  logic [AW-1:0]     err_addr_q;
  logic [NSLAVE-1:0] irq_mask_rd;

  logic [SW-1:0]     slot_in;
  logic              in_int, in_map, in_ack, accept;
  logic [NSLAVE-1:0] onehot_in;
  logic [31:0]       sel_rdata, int_rdata, rd_result;
  logic              ack_sel, access_done, timeout;
  logic [1:0]        err_set, err_clr;
  logic [CW-1:0]     cnt_load;

  assign slot_in = address[AW-1:SLOT_LSB];
  assign in_int  = (slot_in == TOP_SLOT);
  assign accept  = (state == IDLE) && (read || write);

  // Slot decode and slave mux are loops so that an unmapped index never
  // reaches a vector select.
  always_comb begin
    in_map    = 1'b0;
    in_ack    = 1'b0;
    onehot_in = '0;
    sel_rdata = '0;
    ack_sel   = 1'b0;
    for (int i = 0; i < NSLAVE; i++) begin
      if (slot_in == SW'(i)) begin
        in_map       = 1'b1;
        in_ack       = ACK_MASK[i];
        onehot_in[i] = 1'b1;
      end
      if (slot_q == SW'(i)) begin
        sel_rdata = s_readdata[32*i +: 32];
        ack_sel   = s_ack[i];
      end
    end
  end

  always_comb begin
    cnt_load = WS_LOAD;
    if (in_int || !in_map) cnt_load = '0;
    else if (in_ack)       cnt_load = TO_LOAD;
  end

  assign access_done = (state == ACCESS) &&
                       (is_ack_q ? (ack_sel || cnt == '0) : (cnt == '0));
  assign timeout     = (state == ACCESS) && is_ack_q && !ack_sel && (cnt == '0);

  always_comb begin
    int_rdata = '0;
    case (s_address[3:2])
      2'd0:    int_rdata = 32'(irq_in);
      2'd1:    int_rdata = 32'(irq_mask_rd);
      2'd2:    int_rdata = 32'(err_q);
      default: int_rdata = 32'(err_addr_q);
    endcase
  end

  always_comb begin
    rd_result = sel_rdata;
    if (is_int_q)                 rd_result = int_rdata;
    else if (is_unm_q || timeout) rd_result = '0;
  end

  assign err_set = {access_done && is_unm_q, timeout};
  assign err_clr = (access_done && is_int_q && is_wr_q && s_address[3:2] == 2'd2)
                   ? s_data[1:0] : 2'b00;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (read || write) next_state = ACCESS;
      ACCESS:  if (access_done)   next_state = DONE;
      default: next_state = IDLE;
    endcase
  end

  assign wait_out = (state != DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      s_read     <= '0;
      s_write    <= '0;
      s_address  <= '0;
      s_data     <= '0;
      s_be       <= '0;
      slot_q     <= '0;
      is_wr_q    <= 1'b0;
      is_int_q   <= 1'b0;
      is_unm_q   <= 1'b0;
      is_ack_q   <= 1'b0;
      cnt        <= '0;
      data_out   <= '0;
      err_q      <= '0;
      err_addr_q <= '0;
    end else begin
      state   <= next_state;
      s_read  <= '0;
      s_write <= '0;
      if (accept) begin
        s_address <= address[SLOT_LSB-1:0];
        s_data    <= data_in;
        s_be      <= be;
        slot_q    <= slot_in;
        is_wr_q   <= write;
        is_int_q  <= in_int;
        is_unm_q  <= !in_int && !in_map;
        is_ack_q  <= in_ack;
        cnt       <= cnt_load;
        if (in_map) begin
          if (write) s_write <= onehot_in;
          else       s_read  <= onehot_in;
        end
      end else if (state == ACCESS && cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
      if (access_done && !is_wr_q) data_out <= rd_result;
      // A hardware set takes priority over a same-cycle W1C clear.
      err_q <= (err_q & ~err_clr) | err_set;
      if (|err_set) err_addr_q <= {slot_q, s_address};
    end
  end

`ifdef IO_BRIDGE_IRQ_EN
  logic [NSLAVE-1:0] irq_mask_q;
  logic              mask_wr;

  assign mask_wr     = access_done && is_int_q && is_wr_q && s_address[3:2] == 2'd1;
  assign irq_mask_rd = irq_mask_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_mask_q <= '0;
      interrupt  <= 1'b0;
    end else begin
      if (mask_wr) irq_mask_q <= s_data[NSLAVE-1:0];
      interrupt <= |(irq_in & irq_mask_q);
    end
  end
`else
  assign irq_mask_rd = '0;
  assign interrupt   = 1'b0;
`endif

endmodule

// File: tb/tb_io_bridge.sv
// Testbench for io_bridge: directed steps followed by random accesses,
// checked against a transaction-level reference model.
module tb_io_bridge;
  localparam int         NS    = 4;
  localparam int         WS    = 1;
  localparam int         TO    = 8;
  localparam logic [3:0] AMASK = 4'b0100;
`ifdef IO_BRIDGE_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         read = 1'b0, write = 1'b0;
  logic [10:0]  address = '0;
  logic [31:0]  data_in = '0;
  logic [3:0]   be = '0;
  logic [31:0]  data_out;
  logic         wait_out;
  logic [3:0]   s_read, s_write;
  logic [7:0]   s_address;
  logic [31:0]  s_data;
  logic [3:0]   s_be;
  logic [127:0] s_readdata;
  logic [3:0]   s_ack = '0;
  logic [3:0]   irq_in = '0;
  logic         interrupt;
  logic [31:0]  rdata [NS];

  assign s_readdata = {rdata[3], rdata[2], rdata[1], rdata[0]};

  always #5 clk = ~clk;

  io_bridge #(
    .NSLAVE(NS), .AW(11), .SLOT_LSB(8), .WAIT_STATES(WS),
    .ACK_MASK(AMASK), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .read(read), .write(write),
    .address(address), .data_in(data_in), .be(be),
    .data_out(data_out), .wait_out(wait_out),
    .s_read(s_read), .s_write(s_write), .s_address(s_address),
    .s_data(s_data), .s_be(s_be), .s_readdata(s_readdata),
    .s_ack(s_ack), .irq_in(irq_in), .interrupt(interrupt)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [1:0]  m_err = '0;
  logic [10:0] m_eaddr = '0;
  logic [3:0]  m_mask = '0;
  logic [31:0] m_dout = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete CPU access. ack_k is the 1-based ACCESS cycle in which the
  // selected ACK slot acknowledges; values outside 1..TO mean no acknowledge.
  task automatic access(input logic [10:0] addr, input logic rd, input logic wr,
                        input logic [31:0] wd, input logic [3:0] bev,
                        input int ack_k, input logic [3:0] irqv);
    logic [2:0]  slot;
    logic [3:0]  oh, noise;
    logic [31:0] exp_rd;
    bit          is_wr, is_int, is_map, is_ack, tmo;
    int          lat;
    slot   = addr[10:8];
    is_wr  = wr;
    is_int = (slot == 3'd7);
    is_map = (int'(slot) < NS);
    is_ack = is_map && AMASK[slot[1:0]];
    tmo    = is_ack && (ack_k < 1 || ack_k > TO);
    lat    = (is_int || !is_map) ? 1 : (is_ack ? (tmo ? TO : ack_k) : WS);
    oh     = is_map ? (4'(1) << slot) : 4'b0000;
    for (int i = 0; i < NS; i++) rdata[i] = $urandom;
    if (is_int) begin
      case (addr[3:2])
        2'd0:    exp_rd = {28'b0, irqv};
        2'd1:    exp_rd = IRQ_EN ? {28'b0, m_mask} : 32'b0;
        2'd2:    exp_rd = {30'b0, m_err};
        default: exp_rd = {21'b0, m_eaddr};
      endcase
    end else if (!is_map || tmo) begin
      exp_rd = '0;
    end else begin
      exp_rd = rdata[slot[1:0]];
    end

    irq_in = irqv;
    s_ack  = 4'($urandom);
    @(negedge clk);
    chk("interrupt", {31'b0, interrupt}, {31'b0, IRQ_EN && |(irqv & m_mask)});
    read = rd; write = wr; address = addr; data_in = wd; be = bev;
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      chk("s_read",    {28'b0, s_read},  {28'b0, (k == 1 && !is_wr) ? oh : 4'b0});
      chk("s_write",   {28'b0, s_write}, {28'b0, (k == 1 && is_wr) ? oh : 4'b0});
      chk("s_address", {24'b0, s_address}, {24'b0, addr[7:0]});
      chk("s_data",    s_data, wd);
      chk("s_be",      {28'b0, s_be}, {28'b0, bev});
      chk("wait_out",  {31'b0, wait_out}, {31'b0, k != lat + 1});
      if (k == lat + 1) begin
        chk("data_out", data_out, is_wr ? m_dout : exp_rd);
      end else begin
        noise = 4'($urandom);
        s_ack = is_ack ? ((noise & ~oh) | ((k == ack_k) ? oh : 4'b0)) : noise;
      end
    end
    read = 1'b0; write = 1'b0;

    if (!is_wr) m_dout = exp_rd;
    if (tmo) begin m_err[0] = 1'b1; m_eaddr = addr; end
    if (!is_int && !is_map) begin m_err[1] = 1'b1; m_eaddr = addr; end
    if (is_int && is_wr) begin
      if (addr[3:2] == 2'd1 && IRQ_EN) m_mask = wd[3:0];
      if (addr[3:2] == 2'd2) m_err = m_err & ~wd[1:0];
    end
  endtask

  initial begin
    logic [10:0] ra;
    int          mode;
    for (int i = 0; i < NS; i++) rdata[i] = '0;

    // Reset values
    #1;
    chk("rst data_out",  data_out, 32'h0);
    chk("rst wait_out",  {31'b0, wait_out}, 32'h1);
    chk("rst s_read",    {28'b0, s_read}, 32'h0);
    chk("rst s_write",   {28'b0, s_write}, 32'h0);
    chk("rst s_address", {24'b0, s_address}, 32'h0);
    chk("rst s_data",    s_data, 32'h0);
    chk("rst s_be",      {28'b0, s_be}, 32'h0);
    chk("rst interrupt", {31'b0, interrupt}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fixed-latency read, ack-slot write, timeout, error registers
    access(11'h104, 1'b1, 1'b0, 32'h0, 4'hF, 0, 4'h0);
    access(11'h200, 1'b0, 1'b1, 32'hA5, 4'h1, 3, 4'h0);
    access(11'h200, 1'b1, 1'b0, 32'h0, 4'hF, 1, 4'h0);
    access(11'h210, 1'b1, 1'b0, 32'h0, 4'hF, 0, 4'h0);
    access(11'h708, 1'b1, 1'b0, 32'h0, 4'hF, 0, 4'h0);
    access(11'h70C, 1'b1, 1'b0, 32'h0, 4'hF, 0, 4'h0);
    access(11'h500, 1'b1, 1'b0, 32'h0, 4'hF, 0, 4'h0);
    access(11'h708, 1'b1, 1'b0, 32'h0, 4'hF, 0, 4'h0);
    access(11'h708, 1'b0, 1'b1, 32'h2, 4'hF, 0, 4'h0);
    access(11'h708, 1'b1, 1'b0, 32'h0, 4'hF, 0, 4'h0);
    access(11'h70C, 1'b1, 1'b0, 32'h0, 4'hF, 0, 4'h0);

    // Interrupt mask and aggregation
    access(11'h704, 1'b0, 1'b1, 32'h5, 4'hF, 0, 4'h0);
    access(11'h700, 1'b1, 1'b0, 32'h0, 4'hF, 0, 4'b0100);
    access(11'h704, 1'b1, 1'b0, 32'h0, 4'hF, 0, 4'b0010);

    // Back-to-back: request held through DONE is re-accepted in the next IDLE
    irq_in = 4'h0;
    @(negedge clk);
    read = 1'b1; write = 1'b0; address = 11'h104;
    for (int k = 1; k <= 2 * WS + 3; k++) begin
      @(negedge clk);
      chk("b2b s_read", {28'b0, s_read},
          {28'b0, (k == 1 || k == WS + 3) ? 4'b0010 : 4'b0000});
      chk("b2b wait_out", {31'b0, wait_out},
          {31'b0, !(k == WS + 1 || k == 2 * WS + 3)});
      if (k == WS + 3) read = 1'b0;
    end
    m_dout = rdata[1];
    chk("b2b data_out", data_out, m_dout);

    // Random accesses
    for (int n = 0; n < 60; n++) begin
      ra   = {3'($urandom_range(0, 7)), 8'($urandom)};
      mode = $urandom_range(0, 2);
      access(ra, mode != 1, mode != 0, $urandom, 4'($urandom),
             $urandom_range(0, TO + 2), 4'($urandom));
    end

    // Reset in the strobe cycle of an ACK access
    access(11'h704, 1'b0, 1'b1, 32'hF, 4'hF, 0, 4'h0);
    irq_in = 4'b0100;
    @(negedge clk);
    read = 1'b1; address = 11'h210; s_ack = 4'h0;
    @(negedge clk);
    chk("pre-rst s_read", {28'b0, s_read}, 32'h4);
    rst_n = 1'b0;
    #1;
    chk("mid-rst s_read",    {28'b0, s_read}, 32'h0);
    chk("mid-rst s_write",   {28'b0, s_write}, 32'h0);
    chk("mid-rst wait_out",  {31'b0, wait_out}, 32'h1);
    chk("mid-rst interrupt", {31'b0, interrupt}, 32'h0);
    read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_err = '0; m_eaddr = '0; m_mask = '0; m_dout = '0;
    access(11'h000, 1'b1, 1'b0, 32'h0, 4'hF, 0, 4'h0);
    access(11'h708, 1'b1, 1'b0, 32'h0, 4'hF, 0, 4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
